dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/riscv_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory path: owner states, access sizes and
// the default external burst limit used by the data-memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        EXT  = 2'd2
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD       = 3'b010;
    localparam int         EXT_BURST_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core M stage and an external
// loader/debug port. Define ARB_ROUND_ROBIN_EN for round-robin IDLE tie-break.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int EXT_BURST_MAX = EXT_BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        ext_last,
    output logic [31:0] ext_rdata,
    output logic        ext_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    owner_e     state, state_nxt;
    logic [2:0] cnt, cnt_nxt, cnt_inc;
    logic       sel_core, sel_ext;
    logic       tie_ext;
    logic       rd_core_q, rd_ext_q;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who was served last; cleared to favour the core.
    logic last_core;

    always_ff @(posedge clk) begin
        if (rst)           last_core <= 1'b0;
        else if (sel_core) last_core <= 1'b1;
        else if (sel_ext)  last_core <= 1'b0;
    end

    assign tie_ext = last_core;
`else
    assign tie_ext = 1'b0;
`endif

    // An open burst keeps the port while ext has a beat; a gap hands over to the core.
    always_comb begin
        sel_core = 1'b0;
        sel_ext  = 1'b0;
        if (state == EXT && ext_valid) begin
            sel_ext = 1'b1;
        end else if (core_req && ext_valid) begin
            if (tie_ext) sel_ext  = 1'b1;
            else         sel_core = 1'b1;
        end else if (core_req) begin
            sel_core = 1'b1;
        end else if (ext_valid) begin
            sel_ext = 1'b1;
        end
    end

    assign cnt_inc = (cnt == 3'h7) ? cnt : cnt + 3'h1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (sel_core) begin
            state_nxt = CORE;
        end else if (sel_ext) begin
            if (state != EXT) begin
                if (!ext_last) begin
                    state_nxt = EXT;
                    cnt_nxt   = 3'h1;
                end else begin
                    state_nxt = IDLE;
                end
            end else begin
                cnt_nxt = cnt_inc;
                // The burst limit only bites while the core is actually waiting.
                if (ext_last || (core_req && int'(cnt_inc) >= EXT_BURST_MAX))
                    state_nxt = IDLE;
            end
        end else if (state == CORE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'h0;
            rd_core_q <= 1'b0;
            rd_ext_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_core_q <= sel_core & ~core_we;
            rd_ext_q  <= sel_ext & ~ext_we;
        end
    end

    assign core_stall = core_req & ~sel_core;
    assign ext_ready  = sel_ext;

    assign mem_en     = sel_core | sel_ext;
    assign mem_we     = sel_ext ? ext_we    : (sel_core & core_we);
    assign mem_addr   = sel_ext ? ext_addr  : core_addr;
    assign mem_wdata  = sel_ext ? ext_wdata : core_wdata;
    assign mem_funct3 = sel_ext ? FUNCT3_WORD : core_funct3;

    assign core_rvalid = rd_core_q;
    assign ext_rvalid  = rd_ext_q;
    assign core_rdata  = mem_rdata;
    assign ext_rdata   = mem_rdata;

endmodule
